// File: rtl/usb_host_transfer_pkg.sv
// PID[3:2] field encodings, result codes and engine states shared by the host transaction engine.
package usb_defs;

  localparam logic [1:0] TOK_OUT   = 2'b00;
  localparam logic [1:0] TOK_SOF   = 2'b01;
  localparam logic [1:0] TOK_IN    = 2'b10;
  localparam logic [1:0] TOK_SETUP = 2'b11;

  localparam logic [1:0] HSK_ACK   = 2'b00;
  localparam logic [1:0] HSK_NYET  = 2'b01;
  localparam logic [1:0] HSK_NAK   = 2'b10;
  localparam logic [1:0] HSK_STALL = 2'b11;

  localparam logic [1:0] DAT_DATA0 = 2'b00;
  localparam logic [1:0] DAT_DATA2 = 2'b01;
  localparam logic [1:0] DAT_DATA1 = 2'b10;
  localparam logic [1:0] DAT_MDATA = 2'b11;

  localparam logic [2:0] RES_ACK     = 3'd0;
  localparam logic [2:0] RES_NAK     = 3'd1;
  localparam logic [2:0] RES_STALL   = 3'd2;
  localparam logic [2:0] RES_NYET    = 3'd3;
  localparam logic [2:0] RES_TIMEOUT = 3'd4;
  localparam logic [2:0] RES_CRCERR  = 3'd5;
  localparam logic [2:0] RES_DUP     = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE, ST_TOKEN, ST_DATA_TX, ST_WAIT_HSK,
    ST_WAIT_DATA, ST_RX_DATA, ST_SEND_ACK, ST_DONE
  } state_t;

endpackage

// File: rtl/usb_host_transfer_crc5.sv
// Token CRC5 over {endp, addr}, LSB first: poly x^5+x^2+1, seed 1F, inverted, bit-reversed into field order.
module crc5_token (
  input  logic [10:0] data,
  output logic [4:0]  crc
);

  logic [4:0] lfsr;

  always_comb begin
    lfsr = 5'h1f;
    for (int i = 0; i < 11; i++) begin
      if (lfsr[4] ^ data[i]) lfsr = {lfsr[3:0], 1'b0} ^ 5'h05;
      else                   lfsr = {lfsr[3:0], 1'b0};
    end
    crc = ~{lfsr[0], lfsr[1], lfsr[2], lfsr[3], lfsr[4]};
  end

endmodule

// File: rtl/usb_host_transfer.sv
// Host-side USB transaction engine: token, DATAx out or in, handshake, per-endpoint toggles, response timeout.
// state        | meaning
// IDLE         | ready for a command; toggle clear honoured here only
// TOKEN        | token request to encoder until tok_done_i
// DATA_TX      | SETUP/OUT payload streamed to encoder
// WAIT_HSK     | waiting for device handshake or timeout
// WAIT_DATA    | waiting for device DATAx PID, NAK/STALL or timeout
// RX_DATA      | IN payload streamed to user
// SEND_ACK     | ACK request to encoder
// DONE         | result pulse
module usb_host_transfer #(
  parameter int TIMEOUT = 255,
  parameter int TWIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [1:0]  cmd_type_i,
  input  logic [6:0]  cmd_addr_i,
  input  logic [3:0]  cmd_endp_i,
  input  logic        tog_clr_i,
  output logic        res_done_o,
  output logic [2:0]  res_code_o,
  output logic        tok_send_o,
  input  logic        tok_done_i,
  output logic [1:0]  tok_type_o,
  output logic [15:0] tok_data_o,
  output logic        hsk_send_o,
  input  logic        hsk_done_i,
  output logic [1:0]  hsk_type_o,
  output logic        trn_tsend_o,
  output logic [1:0]  trn_ttype_o,
  input  logic        enc_busy_i,
  input  logic        trn_tdone_i,
  input  logic        s_tvalid_i,
  output logic        s_tready_o,
  input  logic        s_tlast_i,
  input  logic [7:0]  s_tdata_i,
  output logic        trn_tvalid_o,
  input  logic        trn_tready_i,
  output logic        trn_tlast_o,
  output logic [7:0]  trn_tdata_o,
  input  logic        hsk_recv_i,
  input  logic [1:0]  hsk_type_i,
  input  logic        dat_recv_i,
  input  logic [1:0]  dat_type_i,
  input  logic        crc_err_i,
  input  logic        rx_tvalid_i,
  output logic        rx_tready_o,
  input  logic        rx_tlast_i,
  input  logic [7:0]  rx_tdata_i,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic        m_tlast_o,
  output logic [7:0]  m_tdata_o
);
  import usb_defs::*;

  state_t            state, state_nxt;
  logic [1:0]        typ;
  logic [3:0]        endp;
  logic [TWIDTH-1:0] timer;
  logic [15:0]       in_tog, out_tog;
  logic              busy_seen;
  logic [1:0]        rx_pid;
  logic [2:0]        pend_code, fin_code;
  logic              load_timer, flip_out, flip_in;
  logic [4:0]        tok_crc;
  logic              accept, rx_last;

  crc5_token u_crc5 (.data({cmd_endp_i, cmd_addr_i}), .crc(tok_crc));

  assign accept      = (state == ST_IDLE) && cmd_valid_i && (cmd_type_i != TOK_SOF);
  assign cmd_ready_o = (state == ST_IDLE);
  assign res_done_o  = (state == ST_DONE);
  assign tok_type_o  = typ;
  assign hsk_type_o  = HSK_ACK;
  assign trn_ttype_o = (typ == TOK_SETUP || !out_tog[endp]) ? DAT_DATA0 : DAT_DATA1;

  assign trn_tvalid_o = (state == ST_DATA_TX) && s_tvalid_i;
  assign s_tready_o   = (state == ST_DATA_TX) && trn_tready_i;
  assign trn_tlast_o  = s_tlast_i;
  assign trn_tdata_o  = s_tdata_i;

  assign m_tvalid_o  = (state == ST_RX_DATA) && rx_tvalid_i;
  assign rx_tready_o = (state == ST_RX_DATA) && m_tready_i;
  assign m_tlast_o   = rx_tlast_i;
  assign m_tdata_o   = rx_tdata_i;
  assign rx_last     = rx_tvalid_i && m_tready_i && rx_tlast_i;

  always_comb begin
    state_nxt   = state;
    fin_code    = pend_code;
    load_timer  = 1'b0;
    flip_out    = 1'b0;
    flip_in     = 1'b0;
    tok_send_o  = 1'b0;
    hsk_send_o  = 1'b0;
    trn_tsend_o = 1'b0;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_TOKEN;
      ST_TOKEN: begin
        tok_send_o = 1'b1;
        if (tok_done_i) begin
          load_timer = (typ == TOK_IN);
          state_nxt  = (typ == TOK_IN) ? ST_WAIT_DATA : ST_DATA_TX;
        end
      end
      ST_DATA_TX: begin
        trn_tsend_o = !busy_seen;
        if (trn_tdone_i) begin
          load_timer = 1'b1;
          state_nxt  = ST_WAIT_HSK;
        end
      end
      ST_WAIT_HSK: begin
        // a handshake arriving in the expiry cycle still counts
        if (hsk_recv_i) begin
          state_nxt = ST_DONE;
          case (hsk_type_i)
            HSK_ACK:  begin fin_code = RES_ACK;  flip_out = 1'b1; end
            HSK_NYET: begin fin_code = RES_NYET; flip_out = 1'b1; end
            HSK_NAK:  fin_code = RES_NAK;
            default:  fin_code = RES_STALL;
          endcase
        end else if (timer == '0) begin
          state_nxt = ST_DONE;
          fin_code  = RES_TIMEOUT;
        end
      end
      ST_WAIT_DATA: begin
        if (dat_recv_i) begin
          if (dat_type_i == DAT_DATA0 || dat_type_i == DAT_DATA1) begin
            state_nxt = ST_RX_DATA;
          end else begin
            state_nxt = ST_DONE;
            fin_code  = RES_CRCERR;
          end
        end else if (hsk_recv_i && (hsk_type_i == HSK_NAK || hsk_type_i == HSK_STALL)) begin
          state_nxt = ST_DONE;
          fin_code  = (hsk_type_i == HSK_NAK) ? RES_NAK : RES_STALL;
        end else if (timer == '0) begin
          state_nxt = ST_DONE;
          fin_code  = RES_TIMEOUT;
        end
      end
      ST_RX_DATA: begin
        if (rx_last) begin
          if (crc_err_i) begin
            state_nxt = ST_DONE;
            fin_code  = RES_CRCERR;
          end else if ((rx_pid == DAT_DATA1) == in_tog[endp]) begin
            state_nxt = ST_SEND_ACK;
            fin_code  = RES_ACK;
            flip_in   = 1'b1;
          end else begin
            state_nxt = ST_SEND_ACK;
            fin_code  = RES_DUP;
          end
        end
      end
      ST_SEND_ACK: begin
        hsk_send_o = 1'b1;
        if (hsk_done_i) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state      <= ST_IDLE;
      typ        <= '0;
      endp       <= '0;
      tok_data_o <= '0;
      timer      <= '0;
      in_tog     <= '0;
      out_tog    <= '0;
      busy_seen  <= 1'b0;
      rx_pid     <= '0;
      pend_code  <= RES_ACK;
      res_code_o <= RES_ACK;
    end else begin
      state     <= state_nxt;
      pend_code <= fin_code;
      if (accept) begin
        typ        <= cmd_type_i;
        endp       <= cmd_endp_i;
        tok_data_o <= {tok_crc, cmd_endp_i, cmd_addr_i};
      end
      if (load_timer)        timer <= TWIDTH'(TIMEOUT);
      else if (timer != '0)  timer <= timer - 1'b1;
      busy_seen <= (state == ST_DATA_TX) && (busy_seen || enc_busy_i);
      if (state == ST_WAIT_DATA && dat_recv_i) rx_pid <= dat_type_i;
      if (state == ST_IDLE && tog_clr_i) begin
        in_tog  <= '0;
        out_tog <= '0;
      end else begin
        // a completed SETUP forces both directions of its endpoint to DATA1
        if (flip_out) begin
          if (typ == TOK_SETUP) begin
            in_tog[endp]  <= 1'b1;
            out_tog[endp] <= 1'b1;
          end else begin
            out_tog[endp] <= ~out_tog[endp];
          end
        end
        if (flip_in) in_tog[endp] <= ~in_tog[endp];
      end
      if (state_nxt == ST_DONE && state != ST_DONE) res_code_o <= fin_code;
    end
  end

endmodule
